// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions used by the divider and the shift-add multiplier.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // ALU function codes, kept in step with the multiplier's operation decoder
  localparam logic [3:0] ALU_ADDU = 4'h0;
  localparam logic [3:0] ALU_SUBU = 4'h1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_remainder_reg.sv
// Combined remainder/quotient register with its load/shift/restore mux and trial subtractor.
import arith_pkg::*;

module div_remainder_reg #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-2:0] quo_shift,
  output logic             borrow
);

  logic [2*WIDTH-1:0] r;
  logic [WIDTH:0]     diff;

  // The shifted upper half is taken W+1 bits wide so the bit pushed out of the
  // top of r still takes part in the trial subtraction.
  assign diff      = r[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
  assign borrow    = diff[WIDTH];
  assign rem_next  = borrow ? r[2*WIDTH-2:WIDTH-1] : diff[WIDTH-1:0];
  assign quo_shift = r[WIDTH-2:0];

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
    end else if (load) begin
      r <= {{WIDTH{1'b0}}, dividend};
    end else if (step) begin
      r <= {rem_next, quo_shift, ~borrow};
    end
  end

endmodule

// File: rtl/comp_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, Run/Ready handshake.
import arith_pkg::*;

module comp_divider #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             Run,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Ready,
  output logic             DivByZero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-2:0] quo_shift;
  logic             borrow;

  assign start = Run && (state != ITER);

  div_remainder_reg #(
    .WIDTH (WIDTH)
  ) u_rem (
    .clk       (clk),
    .reset     (Reset),
    .load      (start),
    .step      (state == ITER),
    .dividend  (Dividend),
    .divisor   (d),
    .rem_next  (rem_next),
    .quo_shift (quo_shift),
    .borrow    (borrow)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      d         <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Ready     <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Run) begin
            d   <= Divisor;
            cnt <= '0;
            if (Divisor == '0) begin
              // Divide by zero skips iteration and reports the conventional result
              state     <= DONE;
              Quotient  <= '1;
              Remainder <= Dividend;
              Ready     <= 1'b1;
              DivByZero <= 1'b1;
            end else begin
              state     <= ITER;
              Ready     <= 1'b0;
              DivByZero <= 1'b0;
            end
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state     <= DONE;
            Quotient  <= {quo_shift, ~borrow};
            Remainder <= rem_next;
            Ready     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/comp_divider.md
Name: comp_divider

Overview:
Sequential unsigned restoring divider, one quotient bit per clock. It is the inverse of the shift-add multiplier in the same arithmetic unit and uses the same Run/Ready handshake.
- A combined remainder/quotient register is shifted left each step.
- The divisor is trial-subtracted from the upper half; the upper half is restored when the result is negative.
- Quotient and remainder are presented once all iterations complete.

Parameters:
WIDTH, 32, operand width (dividend, divisor, quotient, remainder); must be a power of 2 and at least 4.

Ports:
clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Dividend  input  WIDTH  unsigned dividend, sampled only on the start edge
Divisor  input  WIDTH  unsigned divisor, sampled only on the start edge
Run  input  1  start request, level-sampled
Quotient  output  WIDTH  unsigned quotient, valid while Ready=1
Remainder  output  WIDTH  unsigned remainder, valid while Ready=1
Ready  output  1  result valid; stays high until the next accepted Run or Reset
DivByZero  output  1  set with Ready when the start edge saw Divisor==0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (Reset). Reset has priority over every other event.
- Reset values: Quotient=0, Remainder=0, Ready=0, DivByZero=0, state=IDLE, step counter=0, internal register (2*WIDTH bits) cleared.
- States:
  - IDLE: waiting for Run.
  - ITER: performing division steps.
  - DONE: result held.
- Start edge:
  - Run=1 at a rising edge in IDLE or DONE starts an operation. Ready and DivByZero drop at the same edge.
  - Run=1 in ITER is ignored.
  - Run must be a level; no pulse width is required beyond one cycle.
- Load, at the start edge:
  - Internal register R = {WIDTH zeros, Dividend}; divisor latched into D; counter = 0.
  - If Divisor != 0: next state ITER.
  - If Divisor == 0: next state DONE directly. Quotient = all ones, Remainder = Dividend, DivByZero = 1, Ready = 1 one edge after the start.
- ITER, each edge:
  - Shift left: T = R << 1.
  - Trial: diff = T[2W-1:W] - D, computed in W+1 bits.
  - If diff is non-negative (borrow=0): R = {diff[W-1:0], T[W-1:1], 1'b1}.
  - Otherwise: R = {T[2W-1:1], 1'b0}.
  - Counter increments.
  - After the WIDTH-th step (counter==WIDTH-1 at the edge), go to DONE. Quotient = R[W-1:0], Remainder = R[2W-1:W], Ready = 1.
- Latency: the start edge plus WIDTH iteration edges. Ready is observed high after the (WIDTH+1)-th rising edge counted from the start edge (33 for WIDTH=32).
- Quotient and Remainder update only on entry to DONE. During ITER they hold the previous result; Ready=0 marks them stale.
- Dividend and Divisor may change freely after the start edge without affecting the operation in flight.
- Arithmetic invariant for Divisor != 0: Dividend == Quotient*Divisor + Remainder, with Remainder < Divisor.
- Boundary cases:
  - Dividend < Divisor: Q=0, R=Dividend.
  - Divisor=1: Q=Dividend, R=0.
  - Dividend=0: Q=0, R=0.
  - The subtractor must not lose the carry bit when T's upper half is ≥ 2^(W-1).
- Reset during ITER aborts the operation. Outputs return to reset values at that edge; no partial result is exposed.
- Run and Reset high together: Reset wins and the Run is not accepted.
- Back-to-back operation: Run held high in DONE restarts at the next edge. Ready is high for exactly one cycle in that case.

Decomposition:
- Shared package arith_pkg holds:
  - state enum (IDLE, ITER, DONE)
  - ALU function code constants shared with the multiplier (ADDU, SUBU)
  - default WIDTH
  - counter width $clog2(WIDTH)
- One natural sub-module: div_remainder_reg. It holds the 2*WIDTH register, its load/shift/restore mux and the W+1-bit subtractor, and outputs the borrow.
- The top level holds the FSM, counter, divisor register and output registers.

Test Plan:
- Dividend=100, Divisor=7, Run pulsed 1 cycle -> after 33 edges Ready=1, Quotient=14, Remainder=2, DivByZero=0; Ready stays high while Run=0.
- Dividend=0xFFFFFFFF, Divisor=1 -> Quotient=0xFFFFFFFF, Remainder=0; then Dividend=0xFFFFFFFF, Divisor=0x80000000 -> Quotient=1, Remainder=0x7FFFFFFF (carry-bit case).
- Dividend=5, Divisor=0 -> one edge later Ready=1, DivByZero=1, Quotient=0xFFFFFFFF, Remainder=5.
- Dividend=3, Divisor=10 -> Quotient=0, Remainder=3; mid-ITER re-assert Run with new operands -> ignored, result unchanged.
- Start 1000/3, assert Reset at iteration 10 -> next edge Ready=0, Quotient=0, Remainder=0, state IDLE; then 1000/3 -> Quotient=333, Remainder=1.
- Random 10k pairs with Divisor != 0 -> invariant Q*D+R==Dividend and R<D holds; latency is exactly 33 edges on every operation.
